adf4159_prog_sched: RTL and testbench
=====================================

ADF4159_PROG_SCHED -- requirements
Module: adf4159_prog_sched

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning ADF4159 serial-clock half-period in clk cycles (legal 2..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096, meaning the maximum clk cycles to wait for PLL lock after an R0 write.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 6 bits: per-channel write request, level, held until ack.
REQ-006 SHALL have port req_word, input, 192 bits: channel i 32-bit register word at [32i+31:32i].
REQ-007 SHALL have port ack, output, 6 bits: one-cycle pulse, word of channel i captured.
REQ-008 SHALL have port done, output, 6 bits: one-cycle pulse, channel i write (and lock check) finished.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have ports adf4159_clk, adf4159_data and adf4159_le, each output, 6 bits: per-PLL serial clock, data and load enable.
REQ-011 SHALL have port pll_lock, input, 6 bits: asynchronous PLL lock detect; synchronized by 2 flops before use.
REQ-012 SHALL have port lock_err, output, 6 bits: sticky, set when the channel i lock wait times out.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SHIFT_LO, SHIFT_HI, LE_SETUP, LE_HI, LOCK_WAIT, DONE.
REQ-014 SHALL, in IDLE with req nonzero, grant round-robin starting at (last_grant+1) mod 6 and go to LOAD.
REQ-015 SHALL, in LOAD (one cycle), pulse ack[g], latch req_word[g], and drive bit 31 on adf4159_data[g].
REQ-016 SHALL shift MSB first, 32 bits; each bit is CLK_DIV cycles clk low (data changes at start of low) then CLK_DIV cycles clk high.
REQ-017 SHALL, after bit 0 high phase, hold clk low and LE low for CLK_DIV cycles (LE_SETUP), then LE high for CLK_DIV cycles (LE_HI).
REQ-018 SHALL, without lock check, pulse done[g] exactly 66*CLK_DIV+1 cycles after the ack cycle (265 at CLK_DIV=4), then return to IDLE.
REQ-019 SHALL hold adf4159_clk/data/le of non-granted channels at 0 at all times; all serial outputs are 0 in IDLE.
REQ-020 SHALL ignore req changes during a transaction; a new grant is taken only from IDLE, earliest the cycle after done.
REQ-021 SHALL keep last_grant unchanged in IDLE when req is 0.

Reset
REQ-022 SHALL, with rst high at any clock edge, including mid-shift, force IDLE, all outputs to 0, lock_err to 0, and last_grant to 5 so channel 0 wins first.
REQ-023 SHALL emit no done and no ack for a transaction aborted by rst.

Configuration
REQ-024 SHALL use macro ADF4159_LOCK_CHECK_EN.
REQ-025 SHALL, with the macro defined and latched word[2:0]==3'b000 (R0), enter LOCK_WAIT after LE_HI; on synchronized lock high, pulse done and clear lock_err[g].
REQ-026 SHALL, in LOCK_WAIT, on LOCK_TIMEOUT cycles without lock, set lock_err[g] and pulse done[g].
REQ-027 SHALL, with the macro undefined, omit LOCK_WAIT and the lock synchronizer, tie lock_err to 0, and follow REQ-018 timing for all words.

Verification
REQ-028 SHALL verify: req=6'b000100, word2=32'h1123456C -> ack[2] once, 32 bits on adf4159_data[2] MSB-first match, LE pulse of 4 cycles, done[2] 265 cycles after ack.
REQ-029 SHALL verify: req=6'b111111 held -> grant order 0,1,2,3,4,5,0 with one done per grant, no overlap.
REQ-030 SHALL verify: rst asserted at bit 10 of a channel-3 write -> next cycle all outputs 0, no done[3]; after rst, req=6'b001001 grants channel 0 first.
REQ-031 SHALL verify (macro on): R0 word 32'h00000000 on channel 1, pll_lock[1] rises 100 cycles after LE falls -> done[1] within 103 cycles, lock_err[1]=0.
REQ-032 SHALL verify (macro on): R0 write with pll_lock held 0 -> done[1] after 4096 cycles, lock_err[1]=1; a later locked R0 write clears it.
REQ-033 SHALL verify (macro on): R2 word (bits[2:0]=3'b010) -> no LOCK_WAIT, REQ-018 timing.

Source files
------------

// File: rtl/adf4159_prog_sched.sv
// Round-robin serial register programmer for six ADF4159 PLLs (MSB-first, LE strobe).
// Define ADF4159_LOCK_CHECK_EN to wait for PLL lock after every R0 write.
module adf4159_prog_sched #(
  parameter int CLK_DIV      = 4,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   req,
  input  logic [191:0] req_word,
  output logic [5:0]   ack,
  output logic [5:0]   done,
  output logic         busy,
  output logic [5:0]   adf4159_clk,
  output logic [5:0]   adf4159_data,
  output logic [5:0]   adf4159_le,
  input  logic [5:0]   pll_lock,
  output logic [5:0]   lock_err
);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int CW = (LW > 8) ? LW : 8;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT_LO, SHIFT_HI, LE_SETUP, LE_HI, LOCK_WAIT, DONE
  } state_t;

  state_t         state_r;
  logic [2:0]     grant_r;
  logic [2:0]     last_grant_r;
  logic [31:0]    word_r;
  logic [4:0]     bit_r;
  logic [CW-1:0]  cnt_r;

  logic [2:0]     pick_s;
  logic [5:0]     pick_oh_s;
  logic [31:0]    pick_word_s;
  logic [5:0]     sel_s;

  // First requester after last_grant, wrapping modulo 6; i=1 is evaluated last so it wins.
  function automatic logic [2:0] rr_pick(input logic [5:0] r, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] res;
    res = last;
    for (int i = 6; i >= 1; i--) begin
      idx = 3'((int'(last) + i) % 6);
      if (r[idx]) begin
        res = idx;
      end
    end
    return res;
  endfunction

  assign pick_s      = rr_pick(req, last_grant_r);
  assign pick_oh_s   = 6'b000001 << pick_s;
  assign pick_word_s = req_word[{pick_s, 5'd0} +: 32];
  assign sel_s       = 6'b000001 << grant_r;

`ifdef ADF4159_LOCK_CHECK_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  logic [5:0] lock_meta_r;
  logic [5:0] lock_sync_r;

  // Two-flop synchronizer for the asynchronous lock-detect pins
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_r <= 6'b000000;
      lock_sync_r <= 6'b000000;
    end else begin
      lock_meta_r <= pll_lock;
      lock_sync_r <= lock_meta_r;
    end
  end
`else
  logic lock_unused_s;
  assign lock_unused_s = ^pll_lock;
`endif

  // Transaction FSM; every output is registered with the value of the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= 3'd0;
      last_grant_r <= 3'd5;
      word_r       <= 32'h0000_0000;
      bit_r        <= 5'd0;
      cnt_r        <= '0;
      ack          <= 6'b000000;
      done         <= 6'b000000;
      busy         <= 1'b0;
      adf4159_clk  <= 6'b000000;
      adf4159_data <= 6'b000000;
      adf4159_le   <= 6'b000000;
      lock_err     <= 6'b000000;
    end else begin
      ack  <= 6'b000000;
      done <= 6'b000000;
      case (state_r)
        IDLE: begin
          if (req != 6'b000000) begin
            grant_r      <= pick_s;
            last_grant_r <= pick_s;
            word_r       <= pick_word_s;
            ack          <= pick_oh_s;
            adf4159_data <= pick_word_s[31] ? pick_oh_s : 6'b000000;
            busy         <= 1'b1;
            state_r      <= LOAD;
          end else begin
            busy         <= 1'b0;
            adf4159_clk  <= 6'b000000;
            adf4159_data <= 6'b000000;
            adf4159_le   <= 6'b000000;
          end
        end
        LOAD: begin
          bit_r   <= 5'd31;
          cnt_r   <= '0;
          state_r <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r       <= '0;
            adf4159_clk <= sel_s;
            state_r     <= SHIFT_HI;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r       <= '0;
            adf4159_clk <= 6'b000000;
            if (bit_r == 5'd0) begin
              adf4159_data <= 6'b000000;
              state_r      <= LE_SETUP;
            end else begin
              bit_r        <= bit_r - 5'd1;
              adf4159_data <= word_r[bit_r - 5'd1] ? sel_s : 6'b000000;
              state_r      <= SHIFT_LO;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        LE_SETUP: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r      <= '0;
            adf4159_le <= sel_s;
            state_r    <= LE_HI;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        LE_HI: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r      <= '0;
            adf4159_le <= 6'b000000;
`ifdef ADF4159_LOCK_CHECK_EN
            if (word_r[2:0] == 3'b000) begin
              state_r <= LOCK_WAIT;
            end else begin
              done    <= sel_s;
              state_r <= DONE;
            end
`else
            done    <= sel_s;
            state_r <= DONE;
`endif
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
`ifdef ADF4159_LOCK_CHECK_EN
        LOCK_WAIT: begin
          if (lock_sync_r[grant_r]) begin
            lock_err[grant_r] <= 1'b0;
            done              <= sel_s;
            state_r           <= DONE;
          end else if (cnt_r == TMO_LAST) begin
            lock_err[grant_r] <= 1'b1;
            done              <= sel_s;
            state_r           <= DONE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
`endif
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy         <= 1'b0;
          adf4159_clk  <= 6'b000000;
          adf4159_data <= 6'b000000;
          adf4159_le   <= 6'b000000;
          state_r      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adf4159_prog_sched.sv
// Randomized self-checking bench for adf4159_prog_sched against a cycle-count reference model.
module tb_adf4159_prog_sched;
  localparam int C     = 4;
  localparam int T     = 4096;
  localparam int NDONE = 66 * C + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   req;
  logic [191:0] req_word;
  logic [5:0]   ack, done, adf4159_clk, adf4159_data, adf4159_le, pll_lock, lock_err;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;
  int last_g = 5;

  adf4159_prog_sched #(.CLK_DIV(C), .LOCK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_word(req_word),
    .ack(ack), .done(done), .busy(busy),
    .adf4159_clk(adf4159_clk), .adf4159_data(adf4159_data), .adf4159_le(adf4159_le),
    .pll_lock(pll_lock), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [5:0] r);
    for (int i = 1; i <= 6; i++) begin
      if (r[(last_g + i) % 6]) return (last_g + i) % 6;
    end
    return -1;
  endfunction

  task automatic fill_words();
    logic [31:0] w;
    for (int c = 0; c < 6; c++) begin
      w = $urandom;
`ifdef ADF4159_LOCK_CHECK_EN
      w[0] = 1'b1;
`endif
      req_word[32*c +: 32] = w;
    end
  endtask

  // One write: ack, cycle-exact serial waveform, captured word, done latency window [dmin,dmax].
  task automatic txn(input logic [5:0] r, input int dmin, input int dmax, input bit hold,
                     output int g);
    logic [31:0] w, cap;
    logic [5:0]  oh, e_clk, e_data, e_le, m_data;
    bit          hit;
    int          b, ph, kd;
    g = model_pick(r);
    last_g = g;
    w = req_word[32*g +: 32];
    oh = 6'b000001 << g;
    req = r;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != 6'b000000) begin
        hit = 1'b1;
        break;
      end
    end
    chk("ack_seen", hit, 1'b1);
    if (!hit) begin
      req = 6'b000000;
      return;
    end
    cap = 32'h0;
    for (int k = 0; k <= 66 * C; k++) begin
      if (k > 0) @(negedge clk);
      if (!hold && k == 7) req = 6'($urandom);
      e_clk = 6'b0; e_data = 6'b0; e_le = 6'b0; m_data = 6'h3f;
      if (k == 0) begin
        e_data = w[31] ? oh : 6'b0;
      end else if (k <= 64 * C) begin
        b  = (k - 1) / (2 * C);
        ph = (k - 1) % (2 * C);
        if (ph >= C) e_clk = oh;
        if (w[31 - b]) e_data = oh;
        if (ph == C) cap = {cap[30:0], adf4159_data[g]};
      end else begin
        m_data = ~oh;
        if (k > 65 * C) e_le = oh;
      end
      chk("busy", busy, 1'b1);
      chk("ack", ack, (k == 0) ? oh : 6'b0);
      chk("done_early", done, 6'b0);
      chk("sclk", adf4159_clk, e_clk);
      chk("sdata", adf4159_data & m_data, e_data);
      chk("le", adf4159_le, e_le);
    end
    chk("word", cap, w);
    kd = -1;
    for (int k = 66 * C + 1; k <= dmax + 5; k++) begin
      @(negedge clk);
      if (done != 6'b0) begin
        kd = k;
        break;
      end
    end
    chk("done_ch", done, oh);
    chk("done_lat_lo", kd >= dmin, 1'b1);
    chk("done_lat_hi", kd <= dmax, 1'b1);
    if (!hold) req = 6'b000000;
    @(negedge clk);
    chk("done_pulse", done, 6'b0);
  endtask

  initial begin
    int g, n;
    int order [7] = '{0, 1, 2, 3, 4, 5, 0};
    rst = 1'b1; req = 6'b0; pll_lock = 6'b0; req_word = '0;
    fill_words();
    repeat (3) @(negedge clk);
    chk("rst_out", {ack, done, busy, adf4159_clk, adf4159_data, adf4159_le, lock_err}, 37'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Round-robin with all channels held
    for (int i = 0; i < 7; i++) begin
      txn(6'b111111, NDONE, NDONE, 1'b1, g);
      chk("rr_order", g, order[i]);
    end
    req = 6'b0;

    req_word[32*2 +: 32] = 32'h1123456C;
    txn(6'b000100, NDONE, NDONE, 1'b0, g);
    chk("ch2_grant", g, 2);

    for (int i = 0; i < 6; i++) begin
      fill_words();
      txn(6'($urandom_range(1, 63)), NDONE, NDONE, 1'b0, g);
    end

    // Abort a channel-3 write during bit 10
    req = 6'b001000;
    n = 0;
    while (ack == 6'b0 && n < 20) begin @(negedge clk); n++; end
    chk("abort_ack", ack, 6'b001000);
    repeat (1 + 10 * 2 * C) @(negedge clk);
    chk("abort_pre_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out", {ack, done, busy, adf4159_clk, adf4159_data, adf4159_le, lock_err}, 37'h0);
    req = 6'b0;
    @(negedge clk);
    rst = 1'b0;
    last_g = 5;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done != 6'b0 || ack != 6'b0) n++;
    end
    chk("abort_quiet", n, 0);
    txn(6'b001001, NDONE, NDONE, 1'b0, g);
    chk("post_rst_grant", g, 0);

`ifdef ADF4159_LOCK_CHECK_EN
    req_word[32*1 +: 32] = 32'h0000_0000;
    fork
      txn(6'b000010, NDONE + 100, NDONE + 103, 1'b0, g);
      begin : lock_drv
        int m;
        m = 0;
        while (adf4159_le[1] !== 1'b1 && m < 2000) begin @(negedge clk); m++; end
        m = 0;
        while (adf4159_le[1] !== 1'b0 && m < 50) begin @(negedge clk); m++; end
        repeat (100) @(negedge clk);
        pll_lock[1] = 1'b1;
      end
    join
    chk("lock_err_ok", lock_err, 6'b0);
    pll_lock[1] = 1'b0;
    repeat (4) @(negedge clk);
    txn(6'b000010, NDONE + T, NDONE + T, 1'b0, g);
    chk("lock_err_set", lock_err, 6'b000010);
    pll_lock[1] = 1'b1;
    repeat (4) @(negedge clk);
    txn(6'b000010, NDONE + 1, NDONE + 3, 1'b0, g);
    chk("lock_err_clr", lock_err, 6'b0);
    req_word[32*1 +: 32] = 32'h0000_0002;
    pll_lock[1] = 1'b0;
    txn(6'b000010, NDONE, NDONE, 1'b0, g);
    chk("r2_no_wait_err", lock_err, 6'b0);
`else
    req_word[32*4 +: 32] = 32'h0000_0000;
    pll_lock = 6'b111111;
    txn(6'b010000, NDONE, NDONE, 1'b0, g);
    chk("r0_no_lock_err", lock_err, 6'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
